seg7_display_ctrl: RTL

- Parametrised multi-digit 7-segment controller for the DE10-Lite HEX bank. Replaces per-digit HexDriver instances and the hand-built sign/hundreds segment assignments.
- Accepts a binary value with a load strobe. Converts it to hex, or to decimal by sequential double-dabble.
- Applies optional two's-complement sign, leading-zero blanking and overflow indication.
- Drives registered segment bytes for all digits. Sits at top level between game/NIOS status values and HEX0..HEX(N-1).

---
 rtl/seg7_display_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment controller: binary value to hex or decimal (double-dabble)
// with optional sign, leading-zero blanking and overflow dashes.
module seg7_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DATA_W     = 16,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [DATA_W-1:0]       value,
  input  logic                    signed_en,
  input  logic                    dec_mode,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [NUM_DIGITS*8-1:0] seg_out
);

  localparam int unsigned BCD_W = NUM_DIGITS * 4;
  localparam int unsigned EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS + 1);
  localparam int unsigned SEG_W = NUM_DIGITS * 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_FORMAT = 2'd2;

  localparam logic [SEG_W-1:0] SEG_OFF  = {SEG_W{ACTIVE_LOW}};
  localparam logic [7:0]       GLYPH_MINUS = 8'h40;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_neg;
  logic              r_blank;
  logic              r_ovf;
  logic [DATA_W-1:0] r_shift;
  logic [BCD_W-1:0]  r_digits;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_neg;
  logic [DATA_W-1:0] w_mag;
  logic [EXT_W-1:0]  w_mag_ext;
  logic              w_hex_ovf;
  logic [BCD_W-1:0]  w_adj;
  logic [IDX_W-1:0]  w_msd;
  logic [IDX_W-1:0]  w_sign_pos;
  logic              w_fmt_ovf;
  logic [SEG_W-1:0]  w_seg_raw;
  logic [SEG_W-1:0]  w_seg_nxt;

  function automatic logic [7:0] f_glyph(input logic [3:0] d);
    case (d)
      4'h0: f_glyph = 8'h3F;
      4'h1: f_glyph = 8'h06;
      4'h2: f_glyph = 8'h5B;
      4'h3: f_glyph = 8'h4F;
      4'h4: f_glyph = 8'h66;
      4'h5: f_glyph = 8'h6D;
      4'h6: f_glyph = 8'h7D;
      4'h7: f_glyph = 8'h07;
      4'h8: f_glyph = 8'h7F;
      4'h9: f_glyph = 8'h6F;
      4'hA: f_glyph = 8'h77;
      4'hB: f_glyph = 8'h7C;
      4'hC: f_glyph = 8'h39;
      4'hD: f_glyph = 8'h5E;
      4'hE: f_glyph = 8'h79;
      default: f_glyph = 8'h71;
    endcase
  endfunction

  // Magnitude of the incoming value; the most negative number maps onto itself as unsigned.
  always_comb begin
    w_neg     = signed_en & value[DATA_W-1];
    w_mag     = w_neg ? DATA_W'(-value) : value;
    w_mag_ext = EXT_W'(w_mag);
    w_hex_ovf = |(w_mag_ext >> BCD_W);
  end

  always_comb begin
    w_adj = r_digits;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (r_digits[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_digits[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Most significant nonzero digit, sign position and final overflow decision.
  always_comb begin
    w_msd = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (r_digits[i*4 +: 4] != 4'd0) begin
        w_msd = IDX_W'(i);
      end
    end
    w_sign_pos = r_blank ? IDX_W'(w_msd + 1'b1) : IDX_W'(NUM_DIGITS - 1);
    w_fmt_ovf  = r_ovf;
    if (r_neg) begin
      if (r_blank) begin
        w_fmt_ovf = r_ovf | (w_msd == IDX_W'(NUM_DIGITS - 1));
      end else begin
        w_fmt_ovf = r_ovf | (r_digits[BCD_W-1 -: 4] != 4'd0);
      end
    end
  end

  always_comb begin
    w_seg_raw = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (w_fmt_ovf) begin
        w_seg_raw[i*8 +: 8] = GLYPH_MINUS;
      end else if (r_neg && (IDX_W'(i) == w_sign_pos)) begin
        w_seg_raw[i*8 +: 8] = GLYPH_MINUS;
      end else if (r_blank && (IDX_W'(i) > w_msd)) begin
        w_seg_raw[i*8 +: 8] = 8'h00;
      end else begin
        w_seg_raw[i*8 +: 8] = f_glyph(r_digits[i*4 +: 4]);
      end
    end
    w_seg_nxt = ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (load) w_state_nxt = dec_mode ? S_CONV : S_FORMAT;
      S_CONV:   if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = S_FORMAT;
      S_FORMAT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture, shift-add conversion and output registration.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_neg    <= 1'b0;
      r_blank  <= 1'b0;
      r_ovf    <= 1'b0;
      r_shift  <= '0;
      r_digits <= '0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      seg_out  <= SEG_OFF;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            busy    <= 1'b1;
            r_neg   <= w_neg;
            r_blank <= blank_lz;
            r_cnt   <= '0;
            if (dec_mode) begin
              r_shift  <= w_mag;
              r_digits <= '0;
              r_ovf    <= 1'b0;
            end else begin
              r_digits <= BCD_W'(w_mag_ext);
              r_ovf    <= w_hex_ovf;
            end
          end
        end
        S_CONV: begin
          r_digits <= {w_adj[BCD_W-2:0], r_shift[DATA_W-1]};
          r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
          r_ovf    <= r_ovf | w_adj[BCD_W-1];
          r_cnt    <= CNT_W'(r_cnt + 1'b1);
        end
        S_FORMAT: begin
          seg_out  <= w_seg_nxt;
          overflow <= w_fmt_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
